// File: rtl/firc_pkg.sv
// Shared sample types for the complex symmetric FIR: the sample FIFO and
// the FIR datapath both store samples as samp_t.
package firc_pkg;

   localparam int SAMP_W = 24;

   typedef struct packed {
      logic signed [SAMP_W-1:0] i;
      logic signed [SAMP_W-1:0] q;
   } samp_t;

endpackage

// File: rtl/firc_sample_ram.sv
// Sample storage for firc_sample_fifo: DEPTH x samp_t register array with one
// synchronous write port and one asynchronous read port (contents not reset).
module firc_sample_ram
   import firc_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          Clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  samp_t         wr_data,
   input  logic [AW-1:0] rd_addr,
   output samp_t         rd_data
);

   samp_t mem_r [DEPTH];

   // Write port: stores the accepted sample at the write address
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/firc_sample_fifo.sv
// First-word-fall-through complex sample FIFO feeding the FIR control FSM.
// Define FIRC_SAMPLE_FIFO_ERR_EN to add sticky OvfErr/UdfErr outputs.
module firc_sample_fifo
   import firc_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int STOP_MARGIN = 2
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   PushIn,
   input  logic [SAMP_W-1:0]      SampI,
   input  logic [SAMP_W-1:0]      SampQ,
   output logic                   StopIn,
   input  logic                   PullOut,
   output logic [SAMP_W-1:0]      SampIOut,
   output logic [SAMP_W-1:0]      SampQOut,
   output logic                   Empty,
   output logic                   Full,
   output logic [$clog2(DEPTH):0] Count
`ifdef FIRC_SAMPLE_FIFO_ERR_EN
   ,
   output logic                   OvfErr,
   output logic                   UdfErr
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] STOP_LEVEL = PW'(DEPTH - STOP_MARGIN);

   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] count_r;
   logic          stop_r;
   logic [PW-1:0] count_nxt_s;
   logic          push_ok_s;
   logic          pull_ok_s;
   samp_t         wr_data_s;
   samp_t         rd_data_s;

   assign Empty = (wr_ptr_r == rd_ptr_r);
   assign Full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);

   // Handshake acceptance and next occupancy
   always_comb begin
      push_ok_s   = PushIn && (!Full || PullOut);
      pull_ok_s   = PullOut && !Empty;
      count_nxt_s = count_r;
      case ({push_ok_s, pull_ok_s})
         2'b10:   count_nxt_s = count_r + PW'(1);
         2'b01:   count_nxt_s = count_r - PW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy and registered backpressure
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {PW{1'b0}};
         stop_r   <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pull_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r <= count_nxt_s;
         stop_r  <= (count_nxt_s >= STOP_LEVEL);
      end
   end

   assign wr_data_s.i = SampI;
   assign wr_data_s.q = SampQ;

   firc_sample_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .Clk     (Clk),
      .wr_en   (push_ok_s),
      .wr_addr (wr_ptr_r[AW-1:0]),
      .wr_data (wr_data_s),
      .rd_addr (rd_ptr_r[AW-1:0]),
      .rd_data (rd_data_s)
   );

   // Head sample, zeroed while empty so stale storage never leaks out
   always_comb begin
      if (Empty) begin
         SampIOut = {SAMP_W{1'b0}};
         SampQOut = {SAMP_W{1'b0}};
      end else begin
         SampIOut = rd_data_s.i;
         SampQOut = rd_data_s.q;
      end
   end

   assign StopIn = stop_r;
   assign Count  = count_r;

`ifdef FIRC_SAMPLE_FIFO_ERR_EN
   logic ovf_r;
   logic udf_r;

   // Sticky overflow/underflow flags, cleared only by Reset
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else begin
         if (PushIn && Full && !PullOut) begin
            ovf_r <= 1'b1;
         end
         if (PullOut && Empty) begin
            udf_r <= 1'b1;
         end
      end
   end

   assign OvfErr = ovf_r;
   assign UdfErr = udf_r;

`ifndef SYNTHESIS
   // A dropped push means the source ignored StopIn
   always @(posedge Clk) begin
      if (!Reset) begin
         no_overflow: assert (!(PushIn && Full && !PullOut))
            else $warning("firc_sample_fifo: no overflow violated, sample dropped");
      end
   end
`endif
`endif

endmodule

// File: tb/tb_firc_sample_fifo.sv
// Self-checking bench for firc_sample_fifo: directed plan plus random traffic
// against a queue-based reference model.
module tb_firc_sample_fifo;
   import firc_pkg::*;

   localparam int DEPTH       = 16;
   localparam int STOP_MARGIN = 2;

   logic        Clk;
   logic        Reset;
   logic        PushIn;
   logic        PullOut;
   logic [23:0] SampI;
   logic [23:0] SampQ;
   logic        StopIn;
   logic [23:0] SampIOut;
   logic [23:0] SampQOut;
   logic        Empty;
   logic        Full;
   logic [4:0]  Count;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [47:0] model_q[$];
   logic        stop_m;
   int          dut_max;

   firc_sample_fifo #(
      .DEPTH       (DEPTH),
      .STOP_MARGIN (STOP_MARGIN)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .PushIn   (PushIn),
      .SampI    (SampI),
      .SampQ    (SampQ),
      .StopIn   (StopIn),
      .PullOut  (PullOut),
      .SampIOut (SampIOut),
      .SampQOut (SampQOut),
      .Empty    (Empty),
      .Full     (Full),
      .Count    (Count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string ph);
      logic [47:0] head;
      head = (model_q.size() > 0) ? model_q[0] : 48'h0;
      check_val({ph, " count"}, 48'(Count), 48'(model_q.size()));
      check_val({ph, " empty"}, 48'(Empty), 48'(model_q.size() == 0));
      check_val({ph, " full"},  48'(Full),  48'(model_q.size() == DEPTH));
      check_val({ph, " stop"},  48'(StopIn), 48'(stop_m));
      check_val({ph, " head"},  {SampIOut, SampQOut}, head);
   endtask

   // One clock of traffic; model updated from the pre-edge state, DUT checked at the next negedge
   task automatic step(input logic push, input logic pull, input logic [23:0] di,
                       input logic [23:0] dq, input string ph);
      bit do_pull;
      bit do_push;
      PushIn  = push;
      PullOut = pull;
      SampI   = di;
      SampQ   = dq;
      do_pull = pull && (model_q.size() > 0);
      do_push = push && ((model_q.size() < DEPTH) || pull);
      if (do_pull) void'(model_q.pop_front());
      if (do_push) model_q.push_back({di, dq});
      stop_m = (model_q.size() >= DEPTH - STOP_MARGIN);
      @(posedge Clk);
      @(negedge Clk);
      PushIn  = 1'b0;
      PullOut = 1'b0;
      if (int'(Count) > dut_max) dut_max = int'(Count);
      check_all(ph);
   endtask

   initial begin
      Reset   = 1'b1;
      PushIn  = 1'b0;
      PullOut = 1'b0;
      SampI   = 24'h0;
      SampQ   = 24'h0;
      stop_m  = 1'b0;
      dut_max = 0;
      @(negedge Clk);
      check_all("reset");
      Reset = 1'b0;

      // single push then pull
      step(1'b1, 1'b0, 24'h000123, 24'hFFFEDC, "single push");
      check_val("single I", 48'(SampIOut), 48'h000123);
      check_val("single Q", 48'(SampQOut), 48'hFFFEDC);
      check_val("single cnt", 48'(Count), 48'd1);
      step(1'b0, 1'b1, 24'h0, 24'h0, "single pull");
      check_val("pull empty", 48'(Empty), 48'd1);
      check_val("pull outI", 48'(SampIOut), 48'h0);

      // fill to threshold, then to full, then overflow
      for (int k = 0; k < 14; k++) begin
         step(1'b1, 1'b0, 24'(k + 100), 24'(k + 200), "fill");
         if (k == 12) check_val("stop before 14", 48'(StopIn), 48'd0);
      end
      check_val("stop after 14", 48'(StopIn), 48'd1);
      step(1'b1, 1'b0, 24'h00AA15, 24'h00BB15, "fill15");
      step(1'b1, 1'b0, 24'h00AA16, 24'h00BB16, "fill16");
      check_val("full flag", 48'(Full), 48'd1);
      check_val("full count", 48'(Count), 48'd16);
      step(1'b1, 1'b0, 24'hDEAD17, 24'hBEEF17, "overflow");
      check_val("ovf count", 48'(Count), 48'd16);

      // push and pull together while full
      step(1'b1, 1'b1, 24'h7FFFFF, 24'h000001, "full both");
      check_val("full both count", 48'(Count), 48'd16);
      for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 24'h0, 24'h0, "drain");
      check_val("7fffff at head", 48'(SampIOut), 48'h7FFFFF);
      step(1'b0, 1'b1, 24'h0, 24'h0, "drain last");
      step(1'b0, 1'b1, 24'h0, 24'h0, "underflow");

      // push and pull together while empty
      step(1'b1, 1'b1, 24'hABCDEF, 24'h123456, "empty both");
      check_val("empty both count", 48'(Count), 48'd1);
      check_val("empty both I", 48'(SampIOut), 48'hABCDEF);
      step(1'b0, 1'b1, 24'h0, 24'h0, "empty both pull");

      // ordered ramp across several pointer wraps
      dut_max = 0;
      step(1'b1, 1'b0, 24'd0, 24'hFFFFFF, "ramp0");
      for (int v = 1; v < 40; v++) step(1'b1, 1'b1, 24'(v), ~24'(v), "ramp");
      step(1'b0, 1'b1, 24'h0, 24'h0, "ramp tail");
      check_val("ramp max count", 48'(dut_max), 48'd1);

      // async reset mid-stream at Count=9
      for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 24'(k * 3 + 7), 24'(k), "pre reset");
      #2 Reset = 1'b1;
      #1;
      check_val("rst empty", 48'(Empty), 48'd1);
      check_val("rst count", 48'(Count), 48'd0);
      check_val("rst stop", 48'(StopIn), 48'd0);
      check_val("rst outI", 48'(SampIOut), 48'h0);
      #1 Reset = 1'b0;
      model_q.delete();
      stop_m = 1'b0;
      @(negedge Clk);
      check_all("post reset");
      step(1'b1, 1'b0, 24'h055555, 24'h0AAAAA, "post reset push");
      step(1'b0, 1'b1, 24'h0, 24'h0, "post reset pull");

      // random traffic
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
              24'($urandom), 24'($urandom), "random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
